lsu_mem_initiator: RTL
======================

LSU_MEM_INITIATOR -- requirements
Module: lsu_mem_initiator

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, number of 32-bit words in the attached data memory.
REQ-002 SHALL have a single clock, clk, and an asynchronous, active-high reset, rst.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  pipeline presents a load/store request.
REQ-006 req_ready  output  1  block accepts a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-009 req_signed  input  1  sign-extend sub-word loads when 1.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected, qualified by resp_valid.
REQ-015 mem_addr  output  32  word index (req_addr >> 2).
REQ-016 mem_wdata  output  32  word written to memory.
REQ-017 mem_we  output  1  memory write strobe, one cycle.
REQ-018 mem_re  output  1  memory read strobe, one cycle.
REQ-019 mem_rdata  input  32  read word, valid the cycle after mem_re.

Function
REQ-020 SHALL implement FSM states IDLE, RD, CAP, MERGE, WR, RESP and ERR.
REQ-021 req_ready SHALL be 1 only in IDLE; acceptance = req_valid && req_ready, latching all req_* fields.
REQ-022 On acceptance, the request SHALL be an error when:
- req_size == 11;
- halfword with addr[0] = 1;
- word with addr[1:0] != 0;
- (addr >> 2) >= MEM_WORDS.
REQ-023 Error path: IDLE->ERR; in ERR, resp_valid = 1 and resp_err = 1 for one cycle with no mem_re/mem_we, then IDLE.
REQ-024 Load path: IDLE->RD (mem_re = 1) -> CAP (capture mem_rdata, extract) -> RESP.
- resp_valid is asserted 3 cycles after the accepting edge.
REQ-025 Word store path: IDLE->WR (mem_we = 1, mem_wdata = req_wdata) -> RESP.
- resp_valid is asserted 2 cycles after acceptance.
REQ-026 Sub-word store path: IDLE->RD -> MERGE (replace addressed lane(s) of mem_rdata with req_wdata low bits) -> WR (write merged word) -> RESP.
- resp_valid is asserted 4 cycles after acceptance.
REQ-027 Byte lanes SHALL be little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24; halfword offset 2 = bits 31:16.
REQ-028 Load extension SHALL be:
- sign-extend from bit 7/15 when req_signed = 1, otherwise zero-extend;
- word loads returned unmodified.
REQ-029 RESP SHALL pulse resp_valid for exactly one cycle with resp_err = 0, then IDLE; no backpressure on responses.
REQ-030 mem_we and mem_re SHALL never be asserted in the same cycle; mem_addr SHALL hold the latched word index from RD through WR.
REQ-031 req_* changes while not in IDLE SHALL be ignored; at most one request is outstanding.
REQ-032 resp_rdata SHALL hold its value until the next RESP/ERR; mem_wdata SHALL be 0 outside WR.

Reset
REQ-033 rst SHALL immediately force IDLE and set:
- resp_valid = 0, resp_err = 0, resp_rdata = 0;
- mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0;
- req_ready = 1.
REQ-034 Reset asserted mid-operation SHALL abandon the request; no write SHALL occur after rst rises, and no response SHALL be produced for it.

Verification
REQ-035 Word store addr 0x08, data 0xDEADBEEF -> mem_we pulse at word 2 one cycle after acceptance; subsequent word load of 0x08 returns 0xDEADBEEF, resp_valid 3 cycles after acceptance.
REQ-036 Word 2 = 0xDEADBEEF; lb 0x0B signed -> 0xFFFFFFDE; lbu 0x0B -> 0x000000DE; lh 0x08 signed -> 0xFFFFBEEF.
REQ-037 Word 2 = 0xDEADBEEF; sb 0x09 data 0x12 -> mem_re, then mem_we with 0xDEAD12EF; resp_valid 4 cycles after acceptance.
REQ-038 Word load 0x06, halfword 0x03, size 11, and word load 0x100 with MEM_WORDS = 64 -> each gives a one-cycle resp_err = 1 pulse the cycle after acceptance, with no mem_re/mem_we.
REQ-039 Sub-word store with rst asserted during MERGE -> mem_we never pulses, word unchanged, req_ready = 1 after release.
REQ-040 Back-to-back req_valid held high -> req_ready low from acceptance until RESP completes; the second request is accepted in the first IDLE cycle after RESP.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Load/store request, response and data-memory signals between a pipeline, the
// initiator and a single-ported word memory.
interface lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Turns one byte/halfword/word load or store at a time into word accesses on a
// single-ported memory; sub-word stores use read-merge-write.
module lsu_mem_initiator #(
    parameter int unsigned MEM_WORDS = 64
) (
    input logic     clk,
    input logic     rst,
    lsu_mem_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StMerge, StWr, StResp, StErr} state_e;

    state_e      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [4:0]  lane_sh;
    logic [31:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = bus.req_valid && (state_q == StIdle);

    always_comb begin
        req_err = 1'b0;
        case (bus.req_size)
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS) req_err = 1'b1;
    end

    // Lane selection is driven by the latched request, so it is stable from RD onward.
    assign lane_sh   = {addr_q[1:0], 3'b000};
    assign lane_data = bus.mem_rdata >> lane_sh;
    assign lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << lane_sh)
                                         : (32'h0000_FFFF << lane_sh);
    assign merged    = (bus.mem_rdata & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

    always_comb begin
        load_val = bus.mem_rdata;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_val = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err)                                    state_d = StErr;
                    else if (bus.req_write && bus.req_size == 2'b10) state_d = StWr;
                    else                                            state_d = StRd;
                end
            end
            StRd:    state_d = write_q ? StMerge : StCap;
            StCap:   state_d = StResp;
            StMerge: state_d = StWr;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= bus.req_write;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                if (req_err) rdata_q <= 32'h0;
            end
            if (state_q == StCap)   rdata_q <= load_val;
            if (state_q == StMerge) wdata_q <= merged;
            if (state_q == StWr)    rdata_q <= 32'h0;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp) || (state_q == StErr);
    assign bus.resp_err   = (state_q == StErr);
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = {2'b00, addr_q[31:2]};
    assign bus.mem_re     = (state_q == StRd);
    assign bus.mem_we     = (state_q == StWr);
    assign bus.mem_wdata  = (state_q == StWr) ? wdata_q : 32'h0;

endmodule
